rpi_status_tx: RTL

Serial transmitter that sends the game state back to the Raspberry Pi over one GPIO line. It is the return path to the controller inputs, which arrive from the Pi as D-pad, A/B and Pause lines. On each `Send` request it snapshots coins, score and a status byte, then transmits them as a fixed 6-byte UART frame (8N1, LSB first) that the Pi-side software parses. It sits in the `Game` top level beside the input registers and drives one GPIO output pin.

---
 rtl/rpi_status_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rpi_status_tx.sv
// UART status transmitter towards the Raspberry Pi.
// Sends A5, coins, score hi/lo, status and an XOR checksum as 8N1 bytes.
module rpi_status_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Send,
    input  logic [7:0]  Coins,
    input  logic [15:0] Score,
    input  logic [7:0]  Status,
    output logic        Busy,
    output logic        Done,
    output logic        Tx_Serial
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [2:0]      bit_q, bit_n;
    logic [2:0]      byte_q, byte_n;
    logic [7:0]      shift_q, shift_n;
    logic [4:0][7:0] hold_q, hold_n;
    logic            tx_n, busy_n, done_n;
    logic            bit_end;
    logic [7:0]      cur_byte;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        cur_byte = SYNC;
        unique case (byte_q)
            3'd1:    cur_byte = hold_q[0];
            3'd2:    cur_byte = hold_q[1];
            3'd3:    cur_byte = hold_q[2];
            3'd4:    cur_byte = hold_q[3];
            3'd5:    cur_byte = hold_q[4];
            default: cur_byte = SYNC;
        endcase
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        shift_n = shift_q;
        hold_n  = hold_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_n = IDLE;
                if (Send) begin
                    hold_n[0] = Coins;
                    hold_n[1] = Score[15:8];
                    hold_n[2] = Score[7:0];
                    hold_n[3] = Status;
                    hold_n[4] = Coins ^ Score[15:8] ^ Score[7:0] ^ Status;
                    byte_n    = 3'd0;
                    cnt_n     = '0;
                    state_n   = START;
                end
            end
            START: begin
                cnt_n = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    shift_n = cur_byte;
                    state_n = DATA;
                end
            end
            DATA: begin
                cnt_n = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shift_n = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                cnt_n = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_n = '0;
                    if (byte_q < 3'd5) begin
                        byte_n  = byte_q + 1'b1;
                        state_n = START;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        done_n = 1'b0;
        unique case (state_n)
            START: begin
                tx_n   = 1'b0;
                busy_n = 1'b1;
            end
            DATA: begin
                tx_n   = shift_n[0];
                busy_n = 1'b1;
            end
            STOP:    busy_n = 1'b1;
            DONE:    done_n = 1'b1;
            default: tx_n   = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            Tx_Serial <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            byte_q    <= byte_n;
            shift_q   <= shift_n;
            hold_q    <= hold_n;
            Tx_Serial <= tx_n;
            Busy      <= busy_n;
            Done      <= done_n;
        end
    end

endmodule
